mines_reveal_ctrl: RTL and testbench
====================================

// Module: mines_reveal_ctrl
// PURPOSE
//  Game-play stage directly downstream of multi_bomb_placement in the mines game.
//  Latches the placed bomb_grid, accepts player cell selections and reveals each one.
//  Per selection it reports bomb/safe, the adjacent-bomb count and the repeat flag.
//  Tracks the revealed mask and remaining safe cells, and ends the game as LOST or WON.
// PARAMETERS
//  ROWS   4  grid rows
//  COLS   4  grid columns; N = ROWS*COLS cells, idx = row*COLS + col
//  IDX_W  4  width of a cell index, must satisfy 2**IDX_W >= N
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  bomb_grid    in   N        bomb map from multi_bomb_placement, bit idx = 1 means bomb
//  grid_valid   in   1        bomb_grid is stable and final; sampled only in ARM
//  start        in   1        begin a new game; also aborts a game in progress
//  sel_valid    in   1        player selection request
//  sel_idx      in   IDX_W    selected cell index
//  sel_ready    out  1        selection is accepted when sel_valid && sel_ready
//  resp_valid   out  1        one-cycle pulse carrying the result of a selection
//  resp_bomb    out  1        selected cell holds a bomb
//  resp_adj     out  4        bombs among the 8 neighbours (0..8)
//  resp_repeat  out  1        cell was already revealed, or index out of range
//  revealed     out  N        mask of revealed cells
//  safe_left    out  IDX_W+1  unrevealed safe cells remaining
//  game_over    out  1        LOST, held until start
//  game_won     out  1        WON, held until start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; every output is 0; the internal bomb copy is 0.
//  FSM states: IDLE, ARM, PLAY, RESP, LOST, WON.
//   IDLE: on start -> ARM.
//   ARM: on grid_valid, latch bomb_grid; revealed <= 0; safe_left <= N - popcount(bomb_grid).
//     - If that result is 0 -> WON, otherwise -> PLAY. Clear game_over and game_won on entry.
//   PLAY: sel_ready = 1 only if start = 0.
//     - On accept, register sel_idx -> RESP.
//     - On start -> ARM, and no selection is accepted in that cycle (start has priority).
//   RESP (exactly one cycle): resp_valid = 1 with registered results; sel_ready = 0.
//     - Out of range (idx >= N): resp_repeat = 1, resp_bomb = 0, resp_adj = 0; no state change -> PLAY.
//     - Already revealed: resp_repeat = 1; resp_adj recomputed; counters unchanged -> PLAY.
//     - Bomb: revealed[idx] <= 1, resp_bomb = 1, game_over <= 1 -> LOST.
//     - Safe: revealed[idx] <= 1, safe_left <= safe_left - 1.
//       -> WON with game_won <= 1 if safe_left was 1, otherwise -> PLAY.
//   LOST/WON: sel_ready = 0; revealed, safe_left and the flag are held; start -> ARM.
//  Latency: accept at edge T -> resp_valid high for the cycle after T.
//    - Outputs revealed, safe_left and game_* update on the same edge that raises resp_valid.
//    - Maximum rate is one selection per 2 cycles.
//  Adjacency: count only in-grid neighbours; there is no wrap-around across rows or columns.
//    - Example: for COLS=4, idx 3 and idx 4 are not neighbours.
//    - Corners have 3 neighbours and edges have 5.
//  resp_* is valid only while resp_valid = 1 and is held (not cleared) otherwise.
//  Outside ARM: grid_valid and bomb_grid are ignored, so the grid is frozen for the whole game.
//  Outside PLAY: sel_valid is ignored.
//  Reset mid-game: immediate return to IDLE with all outputs 0; no response is emitted.
// TESTING
//  1. reset pulse; start; grid_valid with bomb_grid = 16'h8421
//     -> PLAY next cycle, safe_left = 12, sel_ready = 1.
//  2. Same grid, select idx 1
//     -> next cycle: resp_valid = 1, bomb = 0, adj = 2, repeat = 0; revealed = 16'h0002; safe_left = 11.
//  3. Reselect idx 1 -> resp_repeat = 1, adj = 2, safe_left stays 11.
//     Then select idx 5 -> resp_bomb = 1, game_over = 1, sel_ready = 0 until start.
//  4. bomb_grid = 16'h0008, select idx 4 -> adj = 0 (no row wrap).
//     Then select idx 2 -> adj = 1.
//  5. Grid 16'h8421: reveal all 12 safe cells
//     -> game_won = 1 on the 12th response, safe_left = 0, revealed = 16'h7BDE.
//  6. start and sel_valid asserted together in PLAY -> selection dropped, ARM entered.
//     Separately: reset = 0 during RESP -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/mines_reveal_ctrl_if.sv
// rtl/mines_reveal_ctrl_if.sv - player selection request and reveal response bundle
interface mines_reveal_ctrl_if #(
   parameter int IDX_W = 4
);
   logic             sel_valid;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_ready;
   logic             resp_valid;
   logic             resp_bomb;
   logic [3:0]       resp_adj;
   logic             resp_repeat;

   modport master (
      output sel_valid, sel_idx,
      input  sel_ready, resp_valid, resp_bomb, resp_adj, resp_repeat
   );

   modport slave (
      input  sel_valid, sel_idx,
      output sel_ready, resp_valid, resp_bomb, resp_adj, resp_repeat
   );
endinterface

// File: rtl/mines_reveal_ctrl.sv
// rtl/mines_reveal_ctrl.sv - mines game reveal stage: latches the bomb grid, reveals selections, tracks win/loss
module mines_reveal_ctrl #(
   parameter  int ROWS  = 4,
   parameter  int COLS  = 4,
   parameter  int IDX_W = 4,
   localparam int N     = ROWS * COLS
) (
   input  logic               clk,
   input  logic               reset,
   mines_reveal_ctrl_if.slave sel_if,
   input  logic [N-1:0]       bomb_grid,
   input  logic               grid_valid,
   input  logic               start,
   output logic [N-1:0]       revealed,
   output logic [IDX_W:0]     safe_left,
   output logic               game_over,
   output logic               game_won
);
   typedef enum logic [2:0] {IDLE, ARM, PLAY, RESP, LOST, WON} state_t;

   localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

   state_t           state;
   state_t           resp_next;
   logic [N-1:0]     bombs;
   logic [N-1:0]     sel_mask;
   logic [IDX_W:0]   bomb_cnt;
   logic [IDX_W:0]   safe_init;
   logic [3:0]       adj_cnt;
   logic             in_range;
   logic             sel_bomb;
   logic             sel_seen;

   assign sel_if.sel_ready = (state == PLAY) && !start;
   assign in_range  = {1'b0, sel_if.sel_idx} < N_W;
   assign sel_mask  = N'(1) << sel_if.sel_idx;
   assign sel_bomb  = in_range && bombs[sel_if.sel_idx];
   assign sel_seen  = in_range && revealed[sel_if.sel_idx];
   assign safe_init = N_W - bomb_cnt;

   always_comb begin
      bomb_cnt = '0;
      for (int i = 0; i < N; i++) begin
         bomb_cnt = bomb_cnt + (IDX_W + 1)'(bomb_grid[i]);
      end
   end

   // Neighbours are counted in row/column space so edge cells never wrap onto the next row.
   always_comb begin : adj_calc
      int sr;
      int sc;
      int r;
      int c;
      adj_cnt = '0;
      sr = int'(sel_if.sel_idx) / COLS;
      sc = int'(sel_if.sel_idx) % COLS;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = sr + dr;
            c = sc + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
               if (bombs[IDX_W'(r * COLS + c)]) begin
                  adj_cnt = adj_cnt + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         resp_next          <= IDLE;
         bombs              <= '0;
         revealed           <= '0;
         safe_left          <= '0;
         game_over          <= 1'b0;
         game_won           <= 1'b0;
         sel_if.resp_valid  <= 1'b0;
         sel_if.resp_bomb   <= 1'b0;
         sel_if.resp_adj    <= '0;
         sel_if.resp_repeat <= 1'b0;
      end else begin
         sel_if.resp_valid <= 1'b0;
         case (state)
            IDLE, LOST, WON: begin
               if (start) begin
                  state     <= ARM;
                  game_over <= 1'b0;
                  game_won  <= 1'b0;
               end
            end
            ARM: begin
               if (grid_valid) begin
                  bombs     <= bomb_grid;
                  revealed  <= '0;
                  safe_left <= safe_init;
                  if (safe_init == '0) begin
                     state    <= WON;
                     game_won <= 1'b1;
                  end else begin
                     state <= PLAY;
                  end
               end
            end
            PLAY: begin
               if (start) begin
                  state     <= ARM;
                  game_over <= 1'b0;
                  game_won  <= 1'b0;
               end else if (sel_if.sel_valid) begin
                  // Results and counters commit now so they line up with the resp_valid cycle.
                  state               <= RESP;
                  sel_if.resp_valid   <= 1'b1;
                  sel_if.resp_adj     <= in_range ? adj_cnt : 4'd0;
                  sel_if.resp_bomb    <= sel_bomb && !sel_seen;
                  sel_if.resp_repeat  <= !in_range || sel_seen;
                  if (!in_range || sel_seen) begin
                     resp_next <= PLAY;
                  end else if (sel_bomb) begin
                     revealed  <= revealed | sel_mask;
                     game_over <= 1'b1;
                     resp_next <= LOST;
                  end else begin
                     revealed  <= revealed | sel_mask;
                     safe_left <= safe_left - (IDX_W + 1)'(1);
                     if (safe_left == (IDX_W + 1)'(1)) begin
                        game_won  <= 1'b1;
                        resp_next <= WON;
                     end else begin
                        resp_next <= PLAY;
                     end
                  end
               end
            end
            RESP: begin
               state <= resp_next;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mines_reveal_ctrl.sv
// tb/tb_mines_reveal_ctrl.sv - scoreboard bench for mines_reveal_ctrl
module tb_mines_reveal_ctrl;
   logic        clk;
   logic        reset;
   logic [15:0] bomb_grid;
   logic        grid_valid;
   logic        start;
   logic [15:0] revealed;
   logic [4:0]  safe_left;
   logic        game_over;
   logic        game_won;

   mines_reveal_ctrl_if #(.IDX_W(4)) s_if ();

   mines_reveal_ctrl #(.ROWS(4), .COLS(4), .IDX_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .sel_if     (s_if),
      .bomb_grid  (bomb_grid),
      .grid_valid (grid_valid),
      .start      (start),
      .revealed   (revealed),
      .safe_left  (safe_left),
      .game_over  (game_over),
      .game_won   (game_won)
   );

   typedef struct packed {
      logic        bomb;
      logic [3:0]  adj;
      logic        rpt;
      logic [15:0] rv;
      logic [4:0]  sl;
      logic        go;
      logic        gw;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_rv;
   logic [4:0]  m_sl;
   logic        m_go;
   logic        m_gw;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset && s_if.resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_bomb",   32'(s_if.resp_bomb),   32'(e.bomb));
            chk("resp_adj",    32'(s_if.resp_adj),    32'(e.adj));
            chk("resp_repeat", 32'(s_if.resp_repeat), 32'(e.rpt));
            chk("revealed",    32'(revealed),         32'(e.rv));
            chk("safe_left",   32'(safe_left),        32'(e.sl));
            chk("game_over",   32'(game_over),        32'(e.go));
            chk("game_won",    32'(game_won),         32'(e.gw));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game(input logic [15:0] grid, input logic [4:0] exp_sl);
      start = 1'b1;
      tick();
      start      = 1'b0;
      grid_valid = 1'b1;
      bomb_grid  = grid;
      tick();
      grid_valid = 1'b0;
      chk("arm_sel_ready", 32'(s_if.sel_ready), 32'd1);
      chk("arm_safe_left", 32'(safe_left), 32'(exp_sl));
      chk("arm_revealed",  32'(revealed), 32'd0);
      chk("arm_flags",     32'({game_over, game_won}), 32'd0);
      m_rv = '0;
      m_sl = exp_sl;
      m_go = 1'b0;
      m_gw = 1'b0;
   endtask

   task automatic do_sel(input int idx, input logic bomb, input logic [3:0] adj, input logic rpt);
      int   t;
      exp_t e;
      t = 0;
      while (!s_if.sel_ready && t < 20) begin
         tick();
         t++;
      end
      if (!s_if.sel_ready) begin
         checks++;
         errors++;
         $display("FAIL sel_ready_timeout: got 0 expected 1 for idx %0d", idx);
      end
      if (!rpt) begin
         m_rv = m_rv | (16'd1 << idx);
         if (bomb) begin
            m_go = 1'b1;
         end else begin
            m_sl = m_sl - 5'd1;
            m_gw = (m_sl == 5'd0);
         end
      end
      e.bomb = bomb;
      e.adj  = adj;
      e.rpt  = rpt;
      e.rv   = m_rv;
      e.sl   = m_sl;
      e.go   = m_go;
      e.gw   = m_gw;
      exp_q.push_back(e);
      s_if.sel_valid = 1'b1;
      s_if.sel_idx   = 4'(idx);
      tick();
      s_if.sel_valid = 1'b0;
      tick();
   endtask

   int          safe_idx[12] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14};
   logic [3:0]  safe_adj[12] = '{2, 1, 0, 2, 2, 1, 1, 2, 2, 0, 1, 2};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      start          = 1'b0;
      grid_valid     = 1'b0;
      bomb_grid      = '0;
      s_if.sel_valid = 1'b0;
      s_if.sel_idx   = '0;
      tick();
      tick();
      chk("rst_outputs", 32'({s_if.sel_ready, s_if.resp_valid, s_if.resp_bomb, s_if.resp_adj,
                             s_if.resp_repeat, game_over, game_won}), 32'd0);
      chk("rst_revealed", 32'(revealed), 32'd0);
      chk("rst_safe_left", 32'(safe_left), 32'd0);
      reset = 1'b1;
      tick();

      start_game(16'h8421, 5'd12);
      do_sel(1, 1'b0, 4'd2, 1'b0);
      do_sel(1, 1'b0, 4'd2, 1'b1);
      do_sel(5, 1'b1, 4'd2, 1'b0);
      s_if.sel_valid = 1'b1;
      s_if.sel_idx   = 4'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lost_sel_ready", 32'(s_if.sel_ready), 32'd0);
      end
      s_if.sel_valid = 1'b0;
      chk("lost_held", 32'(game_over), 32'd1);

      start_game(16'h0008, 5'd15);
      do_sel(4, 1'b0, 4'd0, 1'b0);
      do_sel(2, 1'b0, 4'd1, 1'b0);
      do_sel(7, 1'b0, 4'd1, 1'b0);

      start_game(16'h8421, 5'd12);
      for (int i = 0; i < 12; i++) begin
         do_sel(safe_idx[i], 1'b0, safe_adj[i], 1'b0);
      end
      chk("won_revealed", 32'(revealed), 32'h7BDE);
      chk("won_flag", 32'(game_won), 32'd1);
      chk("won_sel_ready", 32'(s_if.sel_ready), 32'd0);

      start_game(16'h8421, 5'd12);
      start          = 1'b1;
      s_if.sel_valid = 1'b1;
      s_if.sel_idx   = 4'd1;
      #1;
      chk("start_blocks_ready", 32'(s_if.sel_ready), 32'd0);
      tick();
      start          = 1'b0;
      s_if.sel_valid = 1'b0;
      grid_valid     = 1'b1;
      bomb_grid      = 16'h0008;
      tick();
      chk("rearm_safe_left", 32'(safe_left), 32'd15);
      chk("rearm_revealed", 32'(revealed), 32'd0);
      m_rv = '0;
      m_sl = 5'd15;
      m_go = 1'b0;
      m_gw = 1'b0;
      bomb_grid = 16'hFFFF;
      do_sel(4, 1'b0, 4'd0, 1'b0);
      grid_valid = 1'b0;

      s_if.sel_valid = 1'b1;
      s_if.sel_idx   = 4'd2;
      tick();
      s_if.sel_valid = 1'b0;
      chk("resp_pulse_before_rst", 32'(s_if.resp_valid), 32'd1);
      reset = 1'b0;
      #1;
      chk("async_rst_resp", 32'({s_if.resp_valid, s_if.resp_bomb, s_if.resp_adj, s_if.resp_repeat}), 32'd0);
      chk("async_rst_status", 32'({revealed, safe_left, game_over, game_won}), 32'd0);
      chk("async_rst_ready", 32'(s_if.sel_ready), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      chk("idle_after_rst", 32'(s_if.sel_ready), 32'd0);
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
